// File: rtl/afx_axis_pkg.sv
// Shared AXI Stream types for the SATA datapath register slices.
package afx_axis_pkg;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_USER_W = 1;

  // PASS: skid empty, beats flow straight through. SKID: one beat parked.
  typedef enum logic {
    PASS = 1'b0,
    SKID = 1'b1
  } skid_state_e;

  // One stream beat as stored by the forward and reverse path stages.
  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_USER_W-1:0] tuser;
    logic                   tlast;
  } axis_beat_t;

endpackage

// File: rtl/afx_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module afx_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear first, otherwise count up until all ones and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/afx_skid_ready_axis.sv
// Reverse-path AXI Stream register slice: s_axis_tready comes from a flop,
// and a single skid entry absorbs the beat accepted while downstream stalls.
module afx_skid_ready_axis
  import afx_axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int USER_W = AXIS_USER_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Same layout as axis_beat_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;
  } beat_t;

  skid_state_e state_q, state_d;
  beat_t       skid_q, skid_d;
  logic        ready_q, ready_d;
  beat_t       s_beat, m_beat;
  logic        s_hs, m_valid;
  logic        inc_beat, inc_frame, inc_stall;

  // Upstream ready is the registered flag, forced low in flush and reset
  // cycles so no upstream handshake can happen while state is being dropped.
  assign s_axis_tready = ready_q & ~flush & rst_n;
  assign s_hs          = s_axis_tvalid & s_axis_tready;

  // Output mux, next state and next skid contents.
  always_comb begin
    s_beat  = '{tdata: s_axis_tdata, tuser: s_axis_tuser, tlast: s_axis_tlast};
    state_d = state_q;
    skid_d  = skid_q;
    m_beat  = s_beat;
    m_valid = s_hs;
    if (state_q == SKID) begin
      m_beat  = skid_q;
      m_valid = 1'b1;
    end
    if (flush || !rst_n) begin
      m_valid = 1'b0;
    end
    if (flush) begin
      state_d = PASS;
      skid_d  = '0;
    end else if (state_q == PASS) begin
      if (s_hs && !m_axis_tready) begin
        skid_d  = s_beat;
        state_d = SKID;
      end
    end else begin
      if (m_axis_tready) begin
        state_d = PASS;
      end
    end
    ready_d = (state_d == PASS) && !flush;
  end

  // State, skid entry and registered upstream ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PASS;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign m_axis_tdata  = m_beat.tdata;
  assign m_axis_tuser  = m_beat.tuser;
  assign m_axis_tlast  = m_beat.tlast;
  assign m_axis_tvalid = m_valid;

  assign inc_beat  = m_valid & m_axis_tready;
  assign inc_frame = inc_beat & m_beat.tlast;
  assign inc_stall = m_valid & ~m_axis_tready;

  afx_sat_counter #(.CNT_W(CNT_W)) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_beat),
    .clr   (cnt_clr),
    .cnt   (beat_cnt)
  );

  afx_sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_frame),
    .clr   (cnt_clr),
    .cnt   (frame_cnt)
  );

  afx_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_stall),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_afx_skid_ready_axis.sv
// Scoreboard bench for afx_skid_ready_axis: a 16-bit-counter instance and a
// 4-bit-counter instance share the same stimulus and the same reference model.
module tb_afx_skid_ready_axis;

  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic [0:0]  s_axis_tuser = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        m_axis_tready = 1'b1;

  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [0:0]  m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic [15:0] beat_cnt, frame_cnt, stall_cnt;

  logic        satSReady;
  logic [31:0] satMData;
  logic [0:0]  satMUser;
  logic        satMLast;
  logic        satMValid;
  logic [3:0]  satBeat, satFrame, satStall;

  int vectors = 0;
  int miscompares = 0;
  logic bpRandom = 1'b0;

  // Reference model state
  beat_t expQ[$];
  beat_t front;
  logic  modelReadyQ = 1'b0;
  logic  readyNext = 1'b0;
  logic  holding, expSReady, expMValid;
  int    expBeat = 0, expFrame = 0, expStall = 0;
  int    expBeatS = 0, expFrameS = 0, expStallS = 0;

  always #5 clk = ~clk;

  afx_skid_ready_axis #(.DATA_W(32), .USER_W(1), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .cnt_clr       (cnt_clr),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .beat_cnt      (beat_cnt),
    .frame_cnt     (frame_cnt),
    .stall_cnt     (stall_cnt)
  );

  afx_skid_ready_axis #(.DATA_W(32), .USER_W(1), .CNT_W(4)) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .cnt_clr       (cnt_clr),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (satSReady),
    .m_axis_tdata  (satMData),
    .m_axis_tuser  (satMUser),
    .m_axis_tlast  (satMLast),
    .m_axis_tvalid (satMValid),
    .m_axis_tready (m_axis_tready),
    .beat_cnt      (satBeat),
    .frame_cnt     (satFrame),
    .stall_cnt     (satStall)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int satInc(input int v, input int maxV);
    return (v < maxV) ? v + 1 : v;
  endfunction

  // Reference model: checks outputs mid-cycle, then advances the model.
  always @(negedge clk) begin
    holding   = (expQ.size() > 0);
    expSReady = rst_n && !flush && modelReadyQ;
    expMValid = rst_n && !flush && (holding || (s_axis_tvalid && expSReady));

    checkOutput("beat_cnt", 64'(beat_cnt), 64'(expBeat));
    checkOutput("frame_cnt", 64'(frame_cnt), 64'(expFrame));
    checkOutput("stall_cnt", 64'(stall_cnt), 64'(expStall));
    checkOutput("sat_beat_cnt", 64'(satBeat), 64'(expBeatS));
    checkOutput("sat_frame_cnt", 64'(satFrame), 64'(expFrameS));
    checkOutput("sat_stall_cnt", 64'(satStall), 64'(expStallS));
    checkOutput("s_ready", 64'(s_axis_tready), 64'(expSReady));
    checkOutput("m_valid", 64'(m_axis_tvalid), 64'(expMValid));
    checkOutput("sat_m_valid", 64'(satMValid), 64'(expMValid));

    if (!rst_n) begin
      expQ.delete();
      expBeat = 0; expFrame = 0; expStall = 0;
      expBeatS = 0; expFrameS = 0; expStallS = 0;
    end else begin
      if (flush && holding) void'(expQ.pop_back());
      if (s_axis_tvalid && expSReady)
        expQ.push_back('{d: s_axis_tdata, u: s_axis_tuser[0], l: s_axis_tlast});
      front = '0;
      if (expMValid) begin
        front = expQ[0];
        checkOutput("m_data", 64'(m_axis_tdata), 64'(front.d));
        checkOutput("m_user", 64'(m_axis_tuser), 64'(front.u));
        checkOutput("m_last", 64'(m_axis_tlast), 64'(front.l));
        checkOutput("sat_m_data", 64'(satMData), 64'(front.d));
        if (m_axis_tready) void'(expQ.pop_front());
      end
      if (cnt_clr) begin
        expBeat = 0; expFrame = 0; expStall = 0;
        expBeatS = 0; expFrameS = 0; expStallS = 0;
      end else begin
        if (expMValid && m_axis_tready) begin
          expBeat  = satInc(expBeat, 65535);
          expBeatS = satInc(expBeatS, 15);
          if (front.l) begin
            expFrame  = satInc(expFrame, 65535);
            expFrameS = satInc(expFrameS, 15);
          end
        end
        if (expMValid && !m_axis_tready) begin
          expStall  = satInc(expStall, 65535);
          expStallS = satInc(expStallS, 15);
        end
      end
    end
    readyNext = rst_n && !flush && (expQ.size() == 0);
  end

  always @(posedge clk) modelReadyQ <= readyNext;

  // Advance one clock; optionally randomise downstream ready.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (bpRandom) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  // Present one beat and hold it until the upstream handshake completes.
  task automatic applyStimulus(input logic [31:0] d, input logic u, input logic l);
    logic hs;
    hs = 1'b0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 500 && !hs; n++) begin
      @(negedge clk);
      hs = s_axis_tready;
      stepCycle();
    end
    if (!hs) checkOutput("send_timeout", 64'(hs), 64'd1);
  endtask

  task automatic sIdle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic clearCounters();
    cnt_clr = 1'b1;
    stepCycle();
    cnt_clr = 1'b0;
  endtask

  task automatic drain();
    sIdle();
    bpRandom = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) stepCycle();
  endtask

  initial begin
    $display("[TB] start");
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
    @(negedge clk);
    checkOutput("rst_ready", 64'(s_axis_tready), 64'd1);
    checkOutput("rst_beat", 64'(beat_cnt), 64'd0);
    stepCycle();

    // Free flow
    clearCounters();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(32'h1000 + 32'(i), 1'b0, i == 7);
    drain();
    @(negedge clk);
    checkOutput("free_beat", 64'(beat_cnt), 64'd8);
    checkOutput("free_frame", 64'(frame_cnt), 64'd1);
    checkOutput("free_stall", 64'(stall_cnt), 64'd0);
    stepCycle();

    // Single stall on 0xA5A5_0003
    clearCounters();
    applyStimulus(32'hA5A5_0001, 1'b1, 1'b0);
    applyStimulus(32'hA5A5_0002, 1'b0, 1'b0);
    s_axis_tdata  = 32'hA5A5_0003;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b0;
    stepCycle();
    s_axis_tdata  = 32'hA5A5_0004;
    m_axis_tready = 1'b1;
    @(negedge clk);
    checkOutput("stall_sready", 64'(s_axis_tready), 64'd0);
    checkOutput("stall_skid", 64'(m_axis_tdata), 64'hA5A5_0003);
    stepCycle();
    applyStimulus(32'hA5A5_0004, 1'b0, 1'b0);
    applyStimulus(32'hA5A5_0005, 1'b0, 1'b1);
    drain();
    @(negedge clk);
    checkOutput("stall_count", 64'(stall_cnt), 64'd1);
    checkOutput("stall_beats", 64'(beat_cnt), 64'd5);
    stepCycle();

    // Random backpressure over 1000 incrementing beats
    clearCounters();
    bpRandom = 1'b1;
    for (int i = 0; i < 1000; i++) applyStimulus(32'(i), 1'(i % 3 == 0), (i % 8) == 7);
    drain();
    @(negedge clk);
    checkOutput("rand_beats", 64'(beat_cnt), 64'd1000);
    checkOutput("rand_frames", 64'(frame_cnt), 64'd125);
    checkOutput("rand_stall", 64'(stall_cnt), 64'(expStall));
    stepCycle();

    // Flush while SKID holds 0xDEAD_BEEF
    m_axis_tready = 1'b0;
    applyStimulus(32'hDEAD_BEEF, 1'b0, 1'b1);
    sIdle();
    @(negedge clk);
    checkOutput("flush_held", 64'(m_axis_tdata), 64'hDEAD_BEEF);
    stepCycle();
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_mvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("flush_sready", 64'(s_axis_tready), 64'd0);
    stepCycle();
    flush = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    checkOutput("post_flush_sready", 64'(s_axis_tready), 64'd0);
    checkOutput("post_flush_mvalid", 64'(m_axis_tvalid), 64'd0);
    stepCycle();
    @(negedge clk);
    checkOutput("flush_recover", 64'(s_axis_tready), 64'd1);
    stepCycle();
    applyStimulus(32'h1234_5678, 1'b0, 1'b1);
    drain();

    // Saturation of the 4-bit counters, then clear racing a handshake
    clearCounters();
    for (int i = 0; i < 20; i++) applyStimulus(32'h5000 + 32'(i), 1'b0, 1'b1);
    drain();
    @(negedge clk);
    checkOutput("sat_hold", 64'(satBeat), 64'd15);
    checkOutput("sat_frame_hold", 64'(satFrame), 64'd15);
    checkOutput("wide_beat", 64'(beat_cnt), 64'd20);
    stepCycle();
    s_axis_tdata  = 32'h0000_C1C1;
    s_axis_tvalid = 1'b1;
    cnt_clr = 1'b1;
    stepCycle();
    cnt_clr = 1'b0;
    sIdle();
    @(negedge clk);
    checkOutput("clr_win_sat", 64'(satBeat), 64'd0);
    checkOutput("clr_win_wide", 64'(beat_cnt), 64'd0);
    stepCycle();

    // Reset while SKID holds a beat
    m_axis_tready = 1'b0;
    applyStimulus(32'h0000_0077, 1'b1, 1'b0);
    sIdle();
    stepCycle();
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
    stepCycle();
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    checkOutput("rst_rel_sready", 64'(s_axis_tready), 64'd0);
    stepCycle();
    @(negedge clk);
    checkOutput("rst_after_sready", 64'(s_axis_tready), 64'd1);
    checkOutput("rst_after_mvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_after_stall", 64'(stall_cnt), 64'd0);
    stepCycle();
    applyStimulus(32'h0000_0088, 1'b0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
